deal_sequencer: RTL and testbench

//  Sequences one blackjack round. Arbitrates a shared card source between player and dealer through a req/ready handshake.

---
 rtl/deal_sequencer_pkg.sv | 53 +++++
 rtl/deal_sequencer_button_edge.sv | 29 ++
 rtl/deal_sequencer.sv | 179 +++++++++++++++++
 tb/tb_deal_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/deal_sequencer_pkg.sv
// Shared definitions for the blackjack round sequencer: default parameters,
// controller state and result encodings, and small state-decoding helpers.
package deal_sequencer_pkg;

  localparam int DEF_CARD_W       = 5;
  localparam int DEF_BUST_LIMIT   = 21;
  localparam int DEF_DEALER_STAND = 17;
  localparam int DEF_REQ_TIMEOUT  = 15;
  localparam int CARD_MIN         = 1;
  localparam int CARD_MAX         = 10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DRAW_P1,
    S_DRAW_D1,
    S_DRAW_P2,
    S_GAP,
    S_CHK_DEAL,
    S_PLAYER,
    S_DRAW_HIT,
    S_CHK_P,
    S_CHK_D,
    S_DRAW_D,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_WIN  = 2'b01,
    RES_LOSE = 2'b10,
    RES_PUSH = 2'b11
  } result_t;

  function automatic logic is_draw(input state_t s);
    return s inside {S_DRAW_P1, S_DRAW_D1, S_DRAW_P2, S_DRAW_HIT, S_DRAW_D};
  endfunction

  function automatic logic draws_for_player(input state_t s);
    return s inside {S_DRAW_P1, S_DRAW_P2, S_DRAW_HIT};
  endfunction

  // Where a draw state goes once its card has been strobed into a hand.
  function automatic state_t after_draw(input state_t s);
    case (s)
      S_DRAW_P1:  return S_DRAW_D1;
      S_DRAW_D1:  return S_DRAW_P2;
      S_DRAW_P2:  return S_CHK_DEAL;
      S_DRAW_HIT: return S_CHK_P;
      default:    return S_CHK_D;
    endcase
  endfunction

endpackage

// File: rtl/deal_sequencer_button_edge.sv
// Two-flop synchroniser for an active-low push button, followed by a
// one-cycle pulse on each press (high-to-low transition).
module button_edge (
  input  logic Clock,
  input  logic reset_n,
  input  logic button,
  output logic press
);

  logic meta;
  logic sync;
  logic sync_q;

  // NOTE: flops reset to the released (high) level so leaving reset never looks like a press.
  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      meta   <= 1'b1;
      sync   <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta   <= button;
      sync   <= meta;
      sync_q <= sync;
    end
  end

  assign press = sync_q & ~sync;

endmodule

// File: rtl/deal_sequencer.sv
// Blackjack round controller: arbitrates the shared card source, strobes cards
// into the player/dealer hand registers and decides the round outcome.
module deal_sequencer
  import deal_sequencer_pkg::*;
#(
  parameter int CARD_W       = DEF_CARD_W,
  parameter int BUST_LIMIT   = DEF_BUST_LIMIT,
  parameter int DEALER_STAND = DEF_DEALER_STAND,
  parameter int REQ_TIMEOUT  = DEF_REQ_TIMEOUT
) (
  input  logic              Clock,
  input  logic              reset_n,
  input  logic              enter,
  input  logic              pass,
  input  logic              card_ready,
  input  logic [CARD_W-1:0] card_value,
  input  logic [CARD_W-1:0] phand,
  input  logic [CARD_W-1:0] dhand,
  output logic              card_req,
  output logic [CARD_W-1:0] card_out,
  output logic              p_add,
  output logic              d_add,
  output logic              clear_hands,
  output logic              busy,
  output logic [1:0]        result
);

  localparam int TO_W = $clog2(REQ_TIMEOUT + 1);

  localparam logic [CARD_W-1:0] CARD_LO = CARD_W'(CARD_MIN);
  localparam logic [CARD_W-1:0] CARD_HI = CARD_W'(CARD_MAX);
  localparam logic [CARD_W-1:0] BUST    = CARD_W'(BUST_LIMIT);
  localparam logic [CARD_W-1:0] STAND   = CARD_W'(DEALER_STAND);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(REQ_TIMEOUT - 1);

  state_t          state;
  state_t          resume;
  logic [TO_W-1:0] to_cnt;
  logic            enter_ev;
  logic            pass_ev;
  logic            card_legal;

  button_edge u_enter_edge (
    .Clock   (Clock),
    .reset_n (reset_n),
    .button  (enter),
    .press   (enter_ev)
  );

  button_edge u_pass_edge (
    .Clock   (Clock),
    .reset_n (reset_n),
    .button  (pass),
    .press   (pass_ev)
  );

  assign card_legal = (card_value >= CARD_LO) && (card_value <= CARD_HI);

  // Every draw, accepted or not, passes through S_GAP: card_req is low there, and
  // for an accepted card the add strobe is live so the CHK state sees the new total.
  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      resume      <= S_IDLE;
      to_cnt      <= '0;
      card_req    <= 1'b0;
      card_out    <= '0;
      p_add       <= 1'b0;
      d_add       <= 1'b0;
      clear_hands <= 1'b0;
      busy        <= 1'b0;
      result      <= RES_NONE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only; strobes default low each cycle.
      p_add       <= 1'b0;
      d_add       <= 1'b0;
      clear_hands <= 1'b0;

      unique case (state)
        S_IDLE, S_DONE: begin
          if (enter_ev) begin
            clear_hands <= 1'b1;
            result      <= RES_NONE;
            card_req    <= 1'b1;
            busy        <= 1'b1;
            state       <= S_DRAW_P1;
          end
        end

        S_DRAW_P1, S_DRAW_D1, S_DRAW_P2, S_DRAW_HIT, S_DRAW_D: begin
          if (card_ready) begin
            card_req <= 1'b0;
            to_cnt   <= '0;
            state    <= S_GAP;
            if (card_legal) begin
              card_out <= card_value;
              p_add    <= draws_for_player(state);
              d_add    <= !draws_for_player(state);
              resume   <= after_draw(state);
            end else begin
              resume   <= state;
            end
          end else if (to_cnt == TO_LAST) begin
            card_req <= 1'b0;
            to_cnt   <= '0;
            resume   <= state;
            state    <= S_GAP;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        S_GAP: begin
          card_req <= is_draw(resume);
          state    <= resume;
        end

        S_CHK_DEAL: begin
          busy <= 1'b0;
          if (phand == BUST) begin
            result <= RES_WIN;
            state  <= S_DONE;
          end else begin
            state <= S_PLAYER;
          end
        end

        S_PLAYER: begin
          // enter is tested first so a simultaneous pass is ignored.
          if (enter_ev) begin
            card_req <= 1'b1;
            busy     <= 1'b1;
            state    <= S_DRAW_HIT;
          end else if (pass_ev) begin
            busy  <= 1'b1;
            state <= S_CHK_D;
          end
        end

        S_CHK_P: begin
          busy <= 1'b0;
          if (phand > BUST) begin
            result <= RES_LOSE;
            state  <= S_DONE;
          end else if (phand == BUST) begin
            result <= RES_WIN;
            state  <= S_DONE;
          end else begin
            state <= S_PLAYER;
          end
        end

        S_CHK_D: begin
          if (dhand > BUST) begin
            result <= RES_WIN;
            busy   <= 1'b0;
            state  <= S_DONE;
          end else if (dhand < STAND) begin
            card_req <= 1'b1;
            state    <= S_DRAW_D;
          end else begin
            busy  <= 1'b0;
            state <= S_DONE;
            if (phand > dhand)      result <= RES_WIN;
            else if (phand < dhand) result <= RES_LOSE;
            else                    result <= RES_PUSH;
          end
        end

        default: begin
          card_req <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deal_sequencer.sv
// Randomised round-level bench for deal_sequencer: a card source, a hand datapath
// and a blackjack rule model that predicts every strobe and each round outcome.
module tb_deal_sequencer;

  localparam int CARD_W   = 5;
  localparam int BUST     = 21;
  localparam int STAND    = 17;
  localparam int TIMEOUT  = 15;
  localparam int R_NONE   = 0;
  localparam int R_WIN    = 1;
  localparam int R_LOSE   = 2;
  localparam int R_PUSH   = 3;

  typedef struct {
    int value;
    int delay;
  } card_t;

  logic              Clock;
  logic              reset_n;
  logic              enter;
  logic              pass;
  logic              card_ready;
  logic [CARD_W-1:0] card_value;
  logic [CARD_W-1:0] phand;
  logic [CARD_W-1:0] dhand;
  logic              card_req;
  logic [CARD_W-1:0] card_out;
  logic              p_add;
  logic              d_add;
  logic              clear_hands;
  logic              busy;
  logic [1:0]        result;

  int n_vec;
  int n_fail;
  int cyc;
  bit all_done;

  card_t script[$];
  bit    who_q[$];
  int    val_q[$];

  bit    prev_req;
  bit    prev_ready;
  int    prev_val;
  int    run;
  bit    need_card;
  int    cur_val;
  int    delay;

  deal_sequencer dut (
    .Clock       (Clock),
    .reset_n     (reset_n),
    .enter       (enter),
    .pass        (pass),
    .card_ready  (card_ready),
    .card_value  (card_value),
    .phand       (phand),
    .dhand       (dhand),
    .card_req    (card_req),
    .card_out    (card_out),
    .p_add       (p_add),
    .d_add       (d_add),
    .clear_hands (clear_hands),
    .busy        (busy),
    .result      (result)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  always @(posedge Clock) cyc++;

  // Hand registers as the real datapath would hold them.
  always @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      phand <= '0;
      dhand <= '0;
    end else if (clear_hands) begin
      phand <= '0;
      dhand <= '0;
    end else begin
      if (p_add) phand <= phand + card_out;
      if (d_add) dhand <= dhand + card_out;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock);
      #2;
    end
  endtask

  function automatic void pick_card();
    card_t c;
    if (script.size() > 0) begin
      c       = script.pop_front();
      cur_val = c.value;
      delay   = c.delay;
    end else begin
      if ($urandom_range(0, 9) == 0)
        cur_val = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(11, 31));
      else
        cur_val = int'($urandom_range(1, 10));
      delay = ($urandom_range(0, 19) == 0) ? 20 : int'($urandom_range(0, 3));
    end
  endfunction

  // Card source plus strobe/handshake monitor, both on the falling edge.
  always @(negedge Clock) begin
    bit cap;
    bit exp_add;
    if (!reset_n) begin
      prev_req   = 1'b0;
      prev_ready = 1'b0;
      prev_val   = 0;
      run        = 0;
      need_card  = 1'b1;
      card_ready = 1'b0;
    end else begin
      cap     = prev_req && prev_ready;
      exp_add = cap && prev_val >= 1 && prev_val <= 10;
      check("add_strobe", int'(p_add) + int'(d_add), int'(exp_add));
      if (exp_add && (p_add ^ d_add)) begin
        check("card_out", int'(card_out), prev_val);
        who_q.push_back(p_add);
        val_q.push_back(prev_val);
      end
      if (card_req) begin
        run++;
      end else begin
        if (prev_req && !cap) check("req_timeout_len", run, TIMEOUT);
        run = 0;
      end
      if (cap) need_card = 1'b1;
      if (card_req && need_card) begin
        pick_card();
        need_card = 1'b0;
      end else if (card_req && delay > 0) begin
        delay--;
      end
      card_ready = card_req && !need_card && delay == 0;
      card_value = CARD_W'(cur_val);
      prev_req   = card_req;
      prev_ready = card_ready;
      prev_val   = cur_val;
    end
  end

  task automatic wait_busy(input logic level, input int limit, output bit ok);
    int n;
    n = 0;
    while (busy !== level && n < limit) begin
      tick(1);
      n++;
    end
    ok = (busy === level);
  endtask

  // Press enter (optionally with pass) or pass alone; hold for `hold` cycles.
  task automatic action(input bit hit, input int hold, input bit both);
    int t0;
    bit ok;
    t0 = cyc;
    if (hit) begin
      enter = 1'b0;
      if (both) pass = 1'b0;
    end else begin
      pass = 1'b0;
    end
    wait_busy(1'b1, 20, ok);
    check("busy_rise", int'(ok), 1);
    if (!ok) finish_run();
    wait_busy(1'b0, 3000, ok);
    check("busy_fall", int'(ok), 1);
    if (!ok) finish_run();
    while (cyc - t0 < hold) tick(1);
    enter = 1'b1;
    pass  = 1'b1;
    tick(4);
  endtask

  task automatic take(input bit exp_player, output int v);
    if (who_q.size() == 0) begin
      check("strobe_present", 0, 1);
      v = 0;
    end else begin
      check("strobe_target", int'(who_q.pop_front()), int'(exp_player));
      v = val_q.pop_front();
    end
  endtask

  // One full round: player hits while below stand_at, then stands.
  task automatic play_round(input int stand_at, input bit special);
    int ph, dh, v0, v1, v2, v, exp_res;
    bit done;
    done    = 1'b0;
    exp_res = R_NONE;
    action(1'b1, int'($urandom_range(1, 4)), 1'b0);
    check("deal_strobes", who_q.size(), 3);
    take(1'b1, v0);
    take(1'b0, v1);
    take(1'b1, v2);
    ph = v0 + v2;
    dh = v1;
    check("phand_deal", int'(phand), ph);
    check("dhand_deal", int'(dhand), dh);
    if (ph == BUST) begin
      exp_res = R_WIN;
      done    = 1'b1;
    end else begin
      check("result_in_play", int'(result), R_NONE);
    end
    while (!done) begin
      if (ph < stand_at) begin
        action(1'b1, special ? 100 : int'($urandom_range(1, 4)), special);
        check("hit_strobes", who_q.size(), 1);
        take(1'b1, v);
        ph += v;
        check("phand_hit", int'(phand), ph);
        if (ph > BUST) begin
          exp_res = R_LOSE;
          done    = 1'b1;
        end else if (ph == BUST) begin
          exp_res = R_WIN;
          done    = 1'b1;
        end else begin
          check("result_in_play", int'(result), R_NONE);
        end
      end else begin
        action(1'b0, int'($urandom_range(1, 4)), 1'b0);
        while (dh < STAND && who_q.size() > 0) begin
          take(1'b0, v);
          dh += v;
        end
        check("dealer_reached_stand", int'(dh >= STAND), 1);
        check("dealer_extra_strobes", who_q.size(), 0);
        check("dhand_final", int'(dhand), dh);
        if (dh > BUST)     exp_res = R_WIN;
        else if (ph > dh)  exp_res = R_WIN;
        else if (ph < dh)  exp_res = R_LOSE;
        else               exp_res = R_PUSH;
        done = 1'b1;
      end
    end
    tick(5);
    check("result", int'(result), exp_res);
    check("busy_after_round", int'(busy), 0);
  endtask

  initial begin
    int n;
    n_vec      = 0;
    n_fail     = 0;
    all_done   = 1'b0;
    reset_n    = 1'b0;
    enter      = 1'b1;
    pass       = 1'b1;
    card_ready = 1'b0;
    card_value = '0;
    tick(3);
    check("rst_card_req", int'(card_req), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_result", int'(result), R_NONE);
    reset_n = 1'b1;
    tick(3);
    check("idle_card_req", int'(card_req), 0);
    check("idle_strobes", int'(p_add) + int'(d_add) + int'(clear_hands), 0);
    check("idle_busy", int'(busy), 0);

    // Abandon a round while the second player card is being requested.
    enter = 1'b0;
    tick(3);
    enter = 1'b1;
    n = 0;
    while (!(who_q.size() == 2 && card_req === 1'b1) && n < 3000) begin
      tick(1);
      n++;
    end
    check("reached_draw_p2", int'(who_q.size() == 2 && card_req === 1'b1), 1);
    #1 reset_n = 1'b0;
    #1;
    check("midreset_card_req", int'(card_req), 0);
    check("midreset_strobes", int'(p_add) + int'(d_add) + int'(clear_hands), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_result", int'(result), R_NONE);
    tick(2);
    who_q.delete();
    val_q.delete();
    script.push_back('{10, 0});
    script.push_back('{5, 0});
    script.push_back('{10, 0});
    script.push_back('{5, 0});
    reset_n = 1'b1;
    tick(3);
    check("post_reset_busy", int'(busy), 0);
    check("post_reset_req", int'(card_req), 0);
    check("post_reset_strobes", who_q.size(), 0);

    // Deal 10,5,10 then hit on 20 with a 5.
    play_round(21, 1'b0);

    // Deal 10,6,9, stand; dealer draws 1 then 10.
    script.push_back('{10, 0});
    script.push_back('{6, 0});
    script.push_back('{9, 0});
    script.push_back('{1, 0});
    script.push_back('{10, 0});
    play_round(19, 1'b0);

    // Slow source, an illegal 0, then one long enter+pass hit.
    script.push_back('{0, 20});
    script.push_back('{7, 0});
    script.push_back('{5, 0});
    script.push_back('{3, 0});
    script.push_back('{4, 0});
    play_round(12, 1'b1);

    for (int r = 0; r < 25; r++)
      play_round(int'($urandom_range(12, 21)), $urandom_range(0, 7) == 0);

    all_done = 1'b1;
    finish_run();
  end

  initial begin
    #900000;
    check("watchdog_completed", int'(all_done), 1);
    finish_run();
  end

endmodule
